// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues credit-limited word reads to imem and queues returned instructions.
// Build option FETCH_MISALIGN_CHK_EN: a misaligned redirect target raises misalign_err and halts fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] op_value,
  output logic [31:0] op_pc,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  output logic        misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] QLAST   = QW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_t;

  state_t        state_reg;
  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] fifo_count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [QW-1:0] iq_rd_reg;
  logic [QW-1:0] iq_wr_reg;
  logic [31:0]   fifo_data_reg [FIFO_DEPTH];
  logic [31:0]   fifo_pc_reg   [FIFO_DEPTH];
  logic [31:0]   iq_pc_reg     [MAX_OUTSTANDING];

  logic [CW:0]   used;
  logic          credit_ok;
  logic          issue;
  logic          resp;
  logic          push;
  logic          pop;
  logic          halt_now;
  logic [31:0]   target_pc;

  // Live requests are those outstanding that will not be dropped; they already own a FIFO slot.
  assign used      = {1'b0, fifo_count_reg} + {1'b0, outstanding_reg} - {1'b0, drop_cnt_reg};
  assign credit_ok = used < DEPTH_C;
  assign imem_req  = (state_reg == RUN) && credit_ok && (outstanding_reg < MAX_C) && !pcsrc;
  assign imem_addr = fetch_pc_reg;
  assign issue     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding_reg != '0);
  assign push      = resp && (drop_cnt_reg == '0) && !pcsrc && (state_reg != HALT);
  assign op_valid  = fifo_count_reg != '0;
  assign pop       = op_valid && op_ready && !pcsrc;
  assign target_pc = pc_target & 32'hFFFF_FFFC;
  assign op_value  = op_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign op_pc     = op_valid ? fifo_pc_reg[rd_ptr_reg] : '0;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_reg;

  assign halt_now     = pcsrc && (pc_target[1:0] != 2'b00);
  assign misalign_err = misalign_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else if (halt_now) begin
      misalign_reg <= 1'b1;
    end
  end
`else
  assign halt_now     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Storage needs no reset: the head is gated by op_valid and entries are written before use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= imem_rdata;
      fifo_pc_reg[wr_ptr_reg]   <= iq_pc_reg[iq_rd_reg];
    end
    if (issue) begin
      iq_pc_reg[iq_wr_reg] <= fetch_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      iq_rd_reg       <= '0;
      iq_wr_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(issue) - CW'(resp);
      if (pcsrc) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc_reg   <= target_pc;
        fifo_count_reg <= '0;
        rd_ptr_reg     <= '0;
        wr_ptr_reg     <= '0;
        iq_rd_reg      <= '0;
        iq_wr_reg      <= '0;
        drop_cnt_reg   <= outstanding_reg - CW'(resp);
      end else begin
        if (issue) begin
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
          iq_wr_reg    <= (iq_wr_reg == QLAST) ? '0 : iq_wr_reg + QW'(1);
        end
        if (resp && (drop_cnt_reg != '0)) begin
          drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          iq_rd_reg  <= (iq_rd_reg == QLAST) ? '0 : iq_rd_reg + QW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
      end

      // A redirect empties the FIFO and retires live credit, so fetch may resume at once.
      case (state_reg)
        BOOT:    state_reg <= RUN;
        RUN:     if (!credit_ok && !pcsrc) state_reg <= HOLD;
        HOLD:    if (credit_ok || pcsrc) state_reg <= RUN;
        default: state_reg <= HALT;
      endcase
      if (halt_now) begin
        state_reg <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random fetch traffic scored against an architectural instruction-stream model,
// plus directed reset, hold, redirect, wrap-around and misaligned-target scenarios.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] op_value;
  logic [31:0] op_pc;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] pc_target = '0;
  logic        misalign_err;

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .op_value(op_value),
    .op_pc(op_pc),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .pcsrc(pcsrc),
    .pc_target(pc_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] next_pc = RESET_PC;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_pops = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          gnt_pct = 100;
  bit          prev_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Called at a falling edge: drives one cycle of inputs, models the memory, updates the stream model.
  task automatic drive_cycle(input bit rst_v, input bit pcsrc_v, input logic [31:0] tgt, input bit rdy);
    pend_t p;
    exp_t  e;
    rst         = rst_v;
    pcsrc       = pcsrc_v;
    pc_target   = tgt;
    op_ready    = rdy;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rst_v) begin
      pend_q.delete();
      exp_q.delete();
      grant_log.delete();
      next_pc = RESET_PC;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p           = pend_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(p.addr);
    end else if (prev_rst) begin
      imem_rvalid = 1'b1;  // stray response with nothing outstanding
    end
    prev_rst = rst_v;
    #1;
    if (!rst_v && imem_req === 1'b1 && imem_gnt) begin
      check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      p.addr = imem_addr;
      p.due  = cyc + $urandom_range(lat_hi, lat_lo);
      pend_q.push_back(p);
      grant_log.push_back(imem_addr);
    end
    if (!rst_v && pcsrc_v) begin
      check("req_in_redirect", {31'd0, imem_req}, 32'd0);
      exp_q.delete();
      next_pc = tgt & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 8) begin
      e.pc   = next_pc;
      e.word = mem_word(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (rst === 1'b0 && op_valid === 1'b1 && op_ready && !pcsrc) begin
      n_pops++;
      check("exp_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("op_pc", op_pc, e.pc);
        check("op_value", op_value, e.word);
      end
      $display("pop pc=%08h value=%08h", op_pc, op_value);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_valid;
    int          pops_before;
    bit          done;
    int          bad;
    logic [31:0] t;

    @(negedge clk);
    repeat (3) drive_cycle(1, 0, 0, 1);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_value", op_value, 32'd0);
    check("rst_op_pc", op_pc, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // First op after reset: BOOT, request, response, FIFO register.
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      if (op_valid === 1'b1 && first_valid < 0) first_valid = i;
      drive_cycle(0, 0, 0, 1);
    end
    check("first_valid_latency", first_valid, 3);

    // Decoder stalled: only FIFO_DEPTH requests may go out.
    repeat (2) drive_cycle(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 0);
    check("hold_grants", grant_log.size(), 2);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 20 && grant_log.size() < 3; i++) drive_cycle(0, 0, 0, 1);
    check("resume_addr", (grant_log.size() >= 3) ? grant_log[2] : 32'hDEAD_DEAD, 32'h8);
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 1);

    // Redirect with two stale requests in flight.
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 40 && pend_q.size() < 2; i++) drive_cycle(0, 0, 0, 1);
    check("two_in_flight", pend_q.size(), 2);
    drive_cycle(0, 1, 32'h100, 0);
    for (int i = 0; i < 20 && op_valid !== 1'b1; i++) drive_cycle(0, 0, 0, 0);
    check("redir_pc", op_pc, 32'h100);
    check("redir_value", op_value, mem_word(32'h100));
    for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0, 1);

    // Redirect coinciding with a response and a pop.
    lat_lo = 1;
    lat_hi = 1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (op_valid === 1'b1 && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        drive_cycle(0, 1, 32'h200, 1);
        done = 1'b1;
      end else begin
        drive_cycle(0, 0, 0, 1);
      end
    end
    check("simul_hit", {31'd0, done}, 32'd1);
    check("simul_empty", {31'd0, op_valid}, 32'd0);
    for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0, 1);

    // Sequential fetch across the top of the address space.
    drive_cycle(0, 1, 32'hFFFF_FFFC, 1);
    grant_log.delete();
    for (int i = 0; i < 20 && grant_log.size() < 2; i++) drive_cycle(0, 0, 0, 1);
    check("wrap_first", (grant_log.size() >= 1) ? grant_log[0] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    check("wrap_next", (grant_log.size() >= 2) ? grant_log[1] : 32'hDEAD_DEAD, 32'h0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 1);

    // Misaligned redirect target.
    drive_cycle(0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("misalign_set", {31'd0, misalign_err}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req !== 1'b0 || op_valid !== 1'b0) bad++;
      drive_cycle(0, 0, 0, 1);
    end
    check("halt_quiet", bad, 0);
    check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    repeat (2) drive_cycle(1, 0, 0, 1);
    check("misalign_clear", {31'd0, misalign_err}, 32'd0);
`else
    bad = 0;
    check("misalign_tied", {31'd0, misalign_err}, 32'd0);
    for (int i = 0; i < 20 && op_valid !== 1'b1; i++) drive_cycle(0, 0, 0, 0);
    check("misalign_pc", op_pc, 32'h100);
    check("misalign_value", op_value, mem_word(32'h100));
`endif

    // Random traffic: variable latency, sparse grants, stalls and redirects.
    repeat (2) drive_cycle(1, 0, 0, 1);
    lat_lo = 1;
    lat_hi = 4;
    gnt_pct = 70;
    pops_before = n_pops;
    for (int i = 0; i < 800; i++) begin
      t = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      t[1:0] = 2'b00;
`endif
      drive_cycle(0, $urandom_range(29) == 0, t, $urandom_range(3) != 0);
    end
    check("random_progress", {31'd0, (n_pops - pops_before) > 100}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit. Produces the 32-bit instruction word (`op_value`) consumed by the decoder.
- Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small FIFO and presents them with a valid/ready handshake.
- Takes the decoder's `pcsrc` decision (target vs. +4) as a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, >=2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..FIFO_DEPTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  memory accepts request this cycle (req&gnt = issued).
- imem_rvalid  in  1  read data valid; responses return in order, >=1 cycle after grant.
- imem_rdata  in  32  instruction word.
- op_value  out  32  instruction to decoder (head of FIFO).
- op_pc  out  32  PC of op_value.
- op_valid  out  1  FIFO non-empty.
- op_ready  in  1  decoder accepts op_value (pop when op_valid&op_ready).
- pcsrc  in  1  redirect strobe: 1 = jump to pc_target, 0 = sequential +4.
- pc_target  in  32  redirect target, sampled when pcsrc=1.
- misalign_err  out  1  see Optional Feature.

Behaviour:
- Reset (rst=1 at clk edge):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
  - Outputs: imem_req=0, imem_addr=RESET_PC, op_valid=0, op_value=0, op_pc=0, misalign_err=0.
  - Reset mid-operation abandons in-flight requests; responses arriving after reset are ignored while drop_cnt=0 and outstanding=0 (rvalid with outstanding=0 is discarded).
- FSM:
  - BOOT: one cycle, no request, then RUN.
  - RUN: may request.
  - HOLD: entered when credit=0, returns to RUN when credit>0.
  - HALT: only with the optional feature.
- Credit: credit = FIFO_DEPTH - fifo_count - (outstanding - drop_cnt).
- imem_req = (state==RUN) & credit>0 & outstanding<MAX_OUTSTANDING & !pcsrc; combinational from registered state.
- imem_addr = fetch_pc.
- On req&gnt: fetch_pc += 4 (wraps mod 2^32); outstanding++.
- On rvalid:
  - outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else push {rdata, pc} into FIFO. The push PC comes from an internal issue-PC queue of depth MAX_OUTSTANDING.
- Pop on op_valid&op_ready. Push and pop in the same cycle keep the count constant; push to a full FIFO cannot occur because of credit.
- Redirect (pcsrc=1):
  - fetch_pc=pc_target, FIFO flushed, issue-PC queue flushed.
  - drop_cnt = outstanding - (rvalid ? 1 : 0); the response arriving in the redirect cycle is also discarded.
  - No request in the redirect cycle. A pop in the same cycle is ignored (flush wins).
  - First request to pc_target is issued the next cycle, if the other issue conditions hold.
- Latency: redirect to first op_valid = 1 cycle + memory latency + 1 cycle (FIFO register).
- Simultaneous pcsrc and rst: rst wins.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - Redirect with pc_target[1:0]!=0 sets misalign_err=1 (sticky until rst).
  - FIFO is flushed and in-flight responses dropped as for a normal redirect.
  - state=HALT; no further requests and op_valid=0 until rst.
- Undefined:
  - pc_target[1:0] forced to 2'b00 on redirect.
  - misalign_err tied 0.
  - HALT unreachable.

Test Plan:
- Reset, gnt=1, memory latency 1, op_ready=1 → addresses 0x0,0x4,0x8... issued back to back; op_value/op_pc appear in order, first op_valid 3 cycles after rst deasserts.
- op_ready=0 for 10 cycles → exactly FIFO_DEPTH (2) requests issued, imem_req=0 (HOLD); release op_ready → fetch resumes at 0x8, no loss or duplicate.
- Latency 3, two requests outstanding (0x10,0x14), pcsrc=1 with pc_target=0x100 → both stale responses discarded, next op_pc=0x100 with correct data, no 0x10/0x14 output.
- pcsrc=1 in the same cycle as rvalid and op_valid&op_ready → that response dropped, pop ignored, FIFO empty next cycle, drop_cnt = remaining outstanding.
- fetch_pc=0xFFFF_FFFC sequential fetch → next imem_addr=0x0000_0000.
- With FETCH_MISALIGN_CHK_EN, pc_target=0x102 → misalign_err=1 next cycle, imem_req stays 0, op_valid=0 until rst. Without the macro → fetch from 0x100.
